// File: rtl/seg_scan_drv.sv
// Time-multiplexed 8-digit seven-segment driver with per-frame shadow capture,
// per-digit decimal point and blink control, and active-low registered outputs.
module seg_scan_drv #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  LE_in,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame
);

  localparam int              PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [7:0]      BLINK_MAX = 8'(BLINK_FRAMES - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_digit;
  logic [7:0]    r_blink_cnt;
  logic          r_blink_ph;
  logic [31:0]   r_disp_sh;
  logic [7:0]    r_point_sh;
  logic [7:0]    r_le_sh;
  logic [7:0]    r_an;
  logic [7:0]    r_seg;
  logic          r_frame;

  logic          w_tick;
  logic          w_frame_bd;
  logic [3:0]    w_nib [8];
  logic [3:0]    w_cur_nib;
  logic [6:0]    w_hex;
  logic          w_blank;
  logic [7:0]    w_an_next;
  logic [7:0]    w_seg_next;

  assign w_tick     = (r_presc == PRESC_MAX);
  assign w_frame_bd = w_tick && (r_digit == 3'd7);

  // Slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_digit <= 3'd0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_digit <= r_digit + 3'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Blink timing advances on every frame, independent of EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blink_cnt <= 8'd0;
      r_blink_ph  <= 1'b0;
    end else if (w_frame_bd) begin
      if (r_blink_cnt == BLINK_MAX) begin
        r_blink_cnt <= 8'd0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  // Shadow registers: the whole frame is drawn from one consistent snapshot
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_disp_sh  <= 32'd0;
      r_point_sh <= 8'd0;
      r_le_sh    <= 8'd0;
    end else if (w_frame_bd && EN) begin
      r_disp_sh  <= Disp_num;
      r_point_sh <= point_in;
      r_le_sh    <= LE_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign w_nib[gi] = r_disp_sh[4*gi +: 4];
    end
  endgenerate

  assign w_cur_nib = w_nib[r_digit];

  always_comb begin
    w_hex = 7'h7F;
    case (w_cur_nib)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
      default: w_hex = 7'h7F;
    endcase
  end

  assign w_blank = !EN || (r_le_sh[r_digit] && r_blink_ph);

  always_comb begin
    w_an_next  = 8'hFF;
    w_seg_next = 8'hFF;
    if (!w_blank) begin
      w_an_next           = 8'hFF;
      w_an_next[r_digit]  = 1'b0;
      w_seg_next          = {~r_point_sh[r_digit], w_hex};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_an    <= 8'hFF;
      r_seg   <= 8'hFF;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an_next;
      r_seg   <= w_seg_next;
      r_frame <= w_frame_bd;
    end
  end

  assign AN      = r_an;
  assign SEGMENT = r_seg;
  assign frame   = r_frame;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with SCAN_DIV=4, BLINK_FRAMES=2 (32-cycle frames).
module tb_seg_scan_drv;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic [31:0] Disp_num;
  logic [7:0]  point_in;
  logic [7:0]  LE_in;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] S_765 = 64'hF8_82_92_99_B0_A4_F9_C0;
  localparam logic [63:0] S_ZER = 64'hC0_C0_C0_C0_C0_C0_C0_C0;
  localparam logic [63:0] S_FFF = 64'h8E_8E_8E_8E_8E_8E_8E_8E;
  localparam logic [63:0] S_888 = 64'h00_80_80_80_80_80_80_00;

  seg_scan_drv #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .EN(EN), .Disp_num(Disp_num), .point_in(point_in),
    .LE_in(LE_in), .AN(AN), .SEGMENT(SEGMENT), .frame(frame)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered on the first cycle of digit 0; leaves on the first cycle of the next frame.
  task automatic show_frame(input string name, input logic [63:0] segs, input logic [7:0] blank,
                            input int chg, input logic [31:0] n_disp,
                            input logic [7:0] n_pt, input logic [7:0] n_le);
    logic [7:0] an_e, seg_e;
    for (int d = 0; d < 8; d++) begin
      an_e  = blank[d] ? 8'hFF : ~(8'h01 << d);
      seg_e = blank[d] ? 8'hFF : segs[8*d +: 8];
      chk($sformatf("%s d%0d AN first", name, d), AN, an_e);
      chk($sformatf("%s d%0d SEG first", name, d), SEGMENT, seg_e);
      if (d == 0) chk($sformatf("%s frame low", name), {7'd0, frame}, 8'd0);
      if (chg == d) begin
        Disp_num = n_disp;
        point_in = n_pt;
        LE_in    = n_le;
      end
      step(3);
      chk($sformatf("%s d%0d AN last", name, d), AN, an_e);
      chk($sformatf("%s d%0d SEG last", name, d), SEGMENT, seg_e);
      if (d == 7) chk($sformatf("%s frame pulse", name), {7'd0, frame}, 8'd1);
      step(1);
    end
    $display("[TB] %s checked", name);
  endtask

  initial begin
    rst = 1'b0; EN = 1'b1; Disp_num = 32'h76543210; point_in = 8'h00; LE_in = 8'h00;
    step(3);
    chk("reset AN", AN, 8'hFF);
    chk("reset SEG", SEGMENT, 8'hFF);
    chk("reset frame", {7'd0, frame}, 8'd0);
    $display("[TB] reset state checked");

    rst = 1'b1;
    step(1);
    show_frame("F1 zero shadow", S_ZER, 8'h00, 8, 32'h0, 8'h00, 8'h00);
    show_frame("F2 76543210", S_765, 8'h00, 3, 32'h00000000, 8'h00, 8'h00);
    show_frame("F3 zeros no tear", S_ZER, 8'h00, 3, 32'hFFFFFFFF, 8'h00, 8'h00);
    show_frame("F4 all F", S_FFF, 8'h00, 3, 32'h88888888, 8'h81, 8'h04);
    show_frame("F5 dp visible", S_888, 8'h00, 8, 32'h0, 8'h00, 8'h00);
    show_frame("F6 dp visible", S_888, 8'h00, 8, 32'h0, 8'h00, 8'h00);
    show_frame("F7 blink off", S_888, 8'h04, 8, 32'h0, 8'h00, 8'h00);
    show_frame("F8 blink off", S_888, 8'h04, 8, 32'h0, 8'h00, 8'h00);
    show_frame("F9 blink on", S_888, 8'h00, 8, 32'h0, 8'h00, 8'h00);

    chk("F10 AN before EN drop", AN, 8'hFE);
    chk("F10 SEG before EN drop", SEGMENT, 8'h00);
    step(5);
    EN = 1'b0; Disp_num = 32'h0; point_in = 8'h00; LE_in = 8'h00;
    step(1);
    chk("EN0 AN", AN, 8'hFF);
    chk("EN0 SEG", SEGMENT, 8'hFF);
    step(25);
    chk("EN0 frame pulse 1", {7'd0, frame}, 8'd1);
    chk("EN0 AN at boundary", AN, 8'hFF);
    step(32);
    chk("EN0 frame pulse 2", {7'd0, frame}, 8'd1);
    $display("[TB] EN=0 blanking checked");
    EN = 1'b1;
    step(1);
    show_frame("F12 shadows held", S_888, 8'h04, 8, 32'h0, 8'h00, 8'h00);
    Disp_num = 32'h76543210;
    show_frame("F13 zeros captured", S_ZER, 8'h00, 8, 32'h0, 8'h00, 8'h00);

    chk("F14 d0 AN", AN, 8'hFE);
    chk("F14 d0 SEG", SEGMENT, 8'hC0);
    step(20);
    chk("F14 d5 AN", AN, 8'hDF);
    chk("F14 d5 SEG", SEGMENT, 8'h92);
    rst = 1'b0;
    step(1);
    chk("midreset AN", AN, 8'hFF);
    chk("midreset SEG", SEGMENT, 8'hFF);
    chk("midreset frame", {7'd0, frame}, 8'd0);
    step(1);
    rst = 1'b1;
    step(1);
    chk("release AN", AN, 8'hFE);
    chk("release SEG", SEGMENT, 8'hC0);
    step(31);
    chk("first frame after release", {7'd0, frame}, 8'd1);
    step(5);
    chk("post-release capture AN", AN, 8'hFD);
    chk("post-release capture SEG", SEGMENT, 8'hF9);
    $display("[TB] mid-frame reset checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_drv.md
SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 Parameter SCAN_DIV, default 50000, meaning clk cycles per digit slot (legal range 2..2^20).
REQ-002 Parameter BLINK_FRAMES, default 64, meaning full 8-digit frames per blink half-period (legal range 1..255).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 EN  input  1  display enable; 0 blanks all digits.
REQ-006 Disp_num  input  32  eight hex nibbles; digit i = Disp_num[4i+3:4i].
REQ-007 point_in  input  8  bit i = 1 lights decimal point of digit i.
REQ-008 LE_in  input  8  bit i = 1 makes digit i blink.
REQ-009 AN  output  8  digit anodes, active-low, registered.
REQ-010 SEGMENT  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
REQ-011 frame  output  1  one-cycle pulse at each frame boundary, registered.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; wrap cycle = slot tick.
REQ-013 Digit index (3 bits) SHALL increment on each slot tick, 7 wraps to 0.
REQ-014 Frame boundary = slot tick while digit index is 7; frame SHALL be 1 on the cycle after that edge, else 0.
REQ-015 At a frame boundary, Disp_num, point_in, LE_in SHALL be captured into shadow registers; display uses only shadow values (no mid-frame tearing).
REQ-016 Shadow capture SHALL occur only when EN=1; with EN=0 shadows hold.
REQ-017 Blink counter SHALL count frame boundaries 0..BLINK_FRAMES-1; on its wrap, blink phase toggles.
REQ-018 Next AN SHALL be all-ones except bit [digit index] = 0.
REQ-019 Next SEGMENT[6:0] SHALL be hex decode of shadow nibble for current digit: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (7-bit hex, active-low).
REQ-020 Next SEGMENT[7] SHALL be ~shadow point bit of current digit.
REQ-021 If shadow LE bit of current digit = 1 and blink phase = 1, AN SHALL be 8'hFF and SEGMENT 8'hFF for that slot.
REQ-022 If EN=0, AN and SEGMENT SHALL be 8'hFF one cycle later; prescaler, digit index and blink continue running.
REQ-023 AN/SEGMENT SHALL change exactly one cycle after digit index changes (one-cycle registered latency); never two AN bits low simultaneously.
REQ-024 Input changes between frame boundaries SHALL have no visible effect until the next boundary.

Reset
REQ-025 rst=0 sampled on a clk edge SHALL set prescaler=0, digit index=0, blink counter=0, blink phase=0, all shadows=0, AN=8'hFF, SEGMENT=8'hFF, frame=0.
REQ-026 Reset mid-frame SHALL abort the frame; first cycle after release, AN=8'hFE, SEGMENT=8'hC0 (shadow 0, dp off).
REQ-027 First shadow capture after reset SHALL occur at the first frame boundary (8*SCAN_DIV cycles after release).

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 Reset release, EN=1, Disp_num=32'h76543210, point_in=0 -> frame pulse after 32 cycles; next frame shows AN=FE/SEGMENT=C0, AN=FD/F9, AN=FB/A4 ... AN=7F/F8, each for 4 cycles.
REQ-029 Disp_num changed from 32'h00000000 to 32'hFFFFFFFF at digit 3 of a frame -> digits 3..7 of that frame still show 0 (C0); next frame all digits show 8E.
REQ-030 point_in=8'h81, Disp_num=32'h88888888 -> digits 0 and 7 SEGMENT=00, digits 1..6 SEGMENT=80.
REQ-031 LE_in=8'h04 -> digit 2 visible in frames 1-2, AN=FF/SEGMENT=FF in its slot in frames 3-4, visible again in frames 5-6; other digits unaffected.
REQ-032 EN=0 mid-frame -> AN=FF, SEGMENT=FF from next cycle; frame pulses continue every 32 cycles; shadows unchanged when EN returns to 1.
REQ-033 rst=0 asserted at digit 5 -> next cycle AN=FF, SEGMENT=FF, frame=0; after release AN=FE, SEGMENT=C0.
